// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage and its fetch buffer.
// Contents:
//   XLEN              datapath width (32)
//   DEFAULT_RESET_PC  PC of the first fetch after reset
//   DEFAULT_NOP_INST  bubble instruction (addi x0,x0,0)
//   fetch_state_e     fetch FSM encodings (IDLE / FETCH / DRAIN)
//   fetch_entry_t     one buffered fetch: {pc, inst}
//   wordAlign()       clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned, so the low two bits of
  // any externally supplied target are simply dropped.
  function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer holding fetched {pc, inst} words between the memory
// port and the IF/ID register.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_push           write i_pushData (ignored when full unless popping too)
//   i_pop            drop the head entry (ignored when empty)
//   i_clear          empty the buffer; takes priority over push/pop
//   i_pushData       entry to write
//   o_headData       oldest entry (meaningless when o_empty)
//   o_count          number of valid entries, 0..DEPTH
//   o_empty          no valid entries
// ---------------------------------------------------------------------------
module fetch_fifo
  import if_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PtrW  = $clog2(DEPTH),
  localparam int CntW  = PtrW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  fetch_entry_t    i_pushData,
  output fetch_entry_t    o_headData,
  output logic [CntW-1:0] o_count,
  output logic            o_empty
);

  fetch_entry_t    r_mem [DEPTH];
  logic [PtrW-1:0] r_wrPtr;
  logic [PtrW-1:0] r_rdPtr;
  logic [CntW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  // A push into a full buffer is still legal when the head leaves on the
  // same edge, which is what lets the stage sustain one word per cycle.
  always_comb begin
    w_full   = (r_count == CntW'(DEPTH));
    w_empty  = (r_count == '0);
    w_doPop  = i_pop && !w_empty;
    w_doPush = i_push && (!w_full || w_doPop);
  end

  // Storage is left without reset: only entries below r_count are ever read.
  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_clear) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; clear simply
  // rewinds everything to the empty state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PtrW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PtrW'(1);
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headData = r_mem[r_rdPtr];
  assign o_count    = r_count;
  assign o_empty    = w_empty;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage with the IF/ID pipeline register. Owns the PC,
// runs a req/ack instruction-memory port, buffers fetched words in a small
// FIFO, holds on decode stall and flushes/refetches on an EX redirect.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   o_imem_req            fetch request, held with stable o_imem_addr until ack
//   o_imem_addr           word-aligned fetch address
//   i_imem_ack            request complete, i_imem_rdata valid this cycle
//   i_imem_rdata          fetched instruction
//   i_id_stall_req        decode stall: hold the IF/ID register
//   i_redirect_valid      taken branch/jump: flush and refetch
//   i_redirect_pc         redirect target (low two bits ignored)
//   o_if_id_valid         IF/ID holds a real instruction
//   o_if_id_inst          instruction to decode, NOP_INST when invalid
//   o_if_id_pc            PC of o_if_id_inst, 0 when invalid
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST   = DEFAULT_NOP_INST
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_id_stall_req,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_id_valid,
  output logic [XLEN-1:0] o_if_id_inst,
  output logic [XLEN-1:0] o_if_id_pc
);

  localparam int              CntW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] FifoDepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_stateNext;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_savedTarget;
  logic            r_pending;

  logic            r_ifIdValid;
  logic [XLEN-1:0] r_ifIdInst;
  logic [XLEN-1:0] r_ifIdPc;

  logic            w_imemReq;
  logic            w_ack;
  logic            w_redirectHold;
  logic [XLEN-1:0] w_redirectTarget;

  logic            w_fifoPush;
  logic            w_fifoPop;
  logic            w_fifoEmpty;
  logic [CntW-1:0] w_fifoCount;
  fetch_entry_t    w_fifoHead;
  fetch_entry_t    w_pushEntry;

  // An ack only counts while we are actually requesting; a stray ack (for
  // example the first cycle after reset, in IDLE) is ignored.
  // A redirect that lands while a request is outstanding and not yet acked
  // cannot abandon that request, so the FSM has to drain it first.
  always_comb begin
    w_ack            = w_imemReq && i_imem_ack;
    w_redirectTarget = wordAlign(i_redirect_pc);
    w_redirectHold   = (r_state == ST_FETCH) && i_redirect_valid &&
                       w_imemReq && !i_imem_ack;
  end

  // Fetch FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fetch FSM next-state logic.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE:  w_stateNext = ST_FETCH;
      ST_FETCH: if (w_redirectHold) w_stateNext = ST_DRAIN;
      ST_DRAIN: if (w_ack)          w_stateNext = ST_FETCH;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Fetch FSM outputs. A new request is only started while the buffer has
  // room, but once raised it stays up until acked (r_pending), so a full
  // buffer never strands an in-flight fetch. DRAIN keeps the old request up.
  always_comb begin
    w_imemReq = 1'b0;
    unique case (r_state)
      ST_FETCH: w_imemReq = (w_fifoCount < FifoDepthCnt) || r_pending;
      ST_DRAIN: w_imemReq = 1'b1;
      default:  w_imemReq = 1'b0;
    endcase
  end

  // PC, outstanding-request flag and saved redirect target. The PC doubles
  // as the memory address, so it must not move while a request is pending;
  // in DRAIN the new target waits in r_savedTarget until the old ack returns.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_savedTarget <= RESET_PC;
      r_pending     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (w_redirectHold) begin
            r_savedTarget <= w_redirectTarget;
            r_pending     <= 1'b1;
          end else if (i_redirect_valid) begin
            r_pc      <= w_redirectTarget;
            r_pending <= 1'b0;
          end else begin
            r_pending <= w_imemReq && !w_ack;
            if (w_ack) begin
              r_pc <= r_pc + XLEN'(4);
            end
          end
        end
        ST_DRAIN: begin
          if (i_redirect_valid) begin
            r_savedTarget <= w_redirectTarget;
          end
          if (w_ack) begin
            r_pc      <= i_redirect_valid ? w_redirectTarget : r_savedTarget;
            r_pending <= 1'b0;
          end
        end
        default: r_pending <= 1'b0;
      endcase
    end
  end

  // Buffer control: only acks accepted in FETCH without a redirect are kept;
  // every redirect flushes the buffer; the head leaves whenever IF/ID loads.
  always_comb begin
    w_fifoPush       = (r_state == ST_FETCH) && w_ack && !i_redirect_valid;
    w_fifoPop        = !i_redirect_valid && !i_id_stall_req && !w_fifoEmpty;
    w_pushEntry.pc   = r_pc;
    w_pushEntry.inst = i_imem_rdata;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetchFifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_fifoPush),
    .i_pop      (w_fifoPop),
    .i_clear    (i_redirect_valid),
    .i_pushData (w_pushEntry),
    .o_headData (w_fifoHead),
    .o_count    (w_fifoCount),
    .o_empty    (w_fifoEmpty)
  );

  // IF/ID register. A redirect always inserts a bubble even under stall,
  // because the held instruction belongs to the squashed path. There is no
  // bypass from the memory port: words always pass through the buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect_valid) begin
      r_ifIdValid <= 1'b0;
      r_ifIdInst  <= NOP_INST;
      r_ifIdPc    <= '0;
    end else if (i_id_stall_req) begin
      r_ifIdValid <= r_ifIdValid;
      r_ifIdInst  <= r_ifIdInst;
      r_ifIdPc    <= r_ifIdPc;
    end else if (!w_fifoEmpty) begin
      r_ifIdValid <= 1'b1;
      r_ifIdInst  <= w_fifoHead.inst;
      r_ifIdPc    <= w_fifoHead.pc;
    end else begin
      r_ifIdValid <= 1'b0;
      r_ifIdInst  <= NOP_INST;
      r_ifIdPc    <= '0;
    end
  end

  assign o_imem_req    = w_imemReq;
  assign o_imem_addr   = r_pc;
  assign o_if_id_valid = r_ifIdValid;
  assign o_if_id_inst  = r_ifIdInst;
  assign o_if_id_pc    = r_ifIdPc;

endmodule
